// File: rtl/cross_mul_sched_if.sv
// cross_mul_sched_if: request/operand/result bundle between two requesters and the shared cross-product unit
interface cross_mul_sched_if;
  logic req0, req1;
  logic [10:0] ax0, ay0, bx0, by0;
  logic [10:0] ax1, ay1, bx1, by1;
  logic gnt0, gnt1, done0, done1;
  logic [22:0] result;
  logic neg, busy;
  modport master (
    output req0, req1, ax0, ay0, bx0, by0, ax1, ay1, bx1, by1,
    input  gnt0, gnt1, done0, done1, result, neg, busy
  );
  modport slave (
    input  req0, req1, ax0, ay0, bx0, by0, ax1, ay1, bx1, by1,
    output gnt0, gnt1, done0, done1, result, neg, busy
  );
endinterface

// File: rtl/cross_mul_sched.sv
// cross_mul_sched: round-robin shared serial multiplier computing ax*by - ay*bx for two requesters
module cross_mul_sched (
  input logic clk,
  input logic reset,
  cross_mul_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL1, MUL2, SUB} state_t;
  state_t state_q, state_d;
  logic prio_q, prio_d, owner_q, owner_d;
  logic [10:0] ax_q, ax_d, ay_q, ay_d, bx_q, bx_d, by_q, by_d;
  logic [3:0] cnt_q, cnt_d;
  logic [20:0] acc_q, acc_d, p1_q, p1_d;
  logic gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
  logic [22:0] result_q, result_d;
  logic neg_q, neg_d;
  function automatic logic [10:0] mag(input logic [10:0] v);
    return v[10] ? 11'(-v) : v;
  endfunction
  function automatic logic sgn(input logic [10:0] a, input logic [10:0] b);
    return (a[10] ^ b[10]) && (a != '0) && (b != '0);
  endfunction
  logic win;
  logic [10:0] mcand, mplier, mshift;
  logic [20:0] acc_nx;
  logic [22:0] p1w, p2w, sp1, sp2, res_nx;
  always_comb begin
    win = (bus.req0 && bus.req1) ? prio_q : bus.req1;
    mcand = (state_q == MUL1) ? mag(ax_q) : mag(ay_q);
    mplier = (state_q == MUL1) ? mag(by_q) : mag(bx_q);
    mshift = mplier >> cnt_q;
    acc_nx = acc_q + (mshift[0] ? (21'(mcand) << cnt_q) : 21'd0);
    p1w = {2'b00, p1_q};
    p2w = {2'b00, acc_q};
    sp1 = sgn(ax_q, by_q) ? 23'd0 - p1w : p1w;
    sp2 = sgn(ay_q, bx_q) ? 23'd0 - p2w : p2w;
    res_nx = sp1 - sp2;
  end
  always_comb begin
    state_d = state_q;
    prio_d = prio_q;
    owner_d = owner_q;
    ax_d = ax_q;
    ay_d = ay_q;
    bx_d = bx_q;
    by_d = by_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    p1_d = p1_q;
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    result_d = result_q;
    neg_d = neg_q;
    case (state_q)
      IDLE: if (bus.req0 || bus.req1) begin
        owner_d = win;
        prio_d = ~win;
        gnt0_d = ~win;
        gnt1_d = win;
        ax_d = win ? bus.ax1 : bus.ax0;
        ay_d = win ? bus.ay1 : bus.ay0;
        bx_d = win ? bus.bx1 : bus.bx0;
        by_d = win ? bus.by1 : bus.by0;
        cnt_d = 4'd0;
        acc_d = 21'd0;
        state_d = MUL1;
      end
      MUL1: begin
        cnt_d = (cnt_q == 4'd10) ? 4'd0 : cnt_q + 4'd1;
        acc_d = (cnt_q == 4'd10) ? 21'd0 : acc_nx;
        p1_d = (cnt_q == 4'd10) ? acc_nx : p1_q;
        state_d = (cnt_q == 4'd10) ? MUL2 : MUL1;
      end
      MUL2: begin
        cnt_d = (cnt_q == 4'd10) ? 4'd0 : cnt_q + 4'd1;
        acc_d = acc_nx;
        state_d = (cnt_q == 4'd10) ? SUB : MUL2;
      end
      SUB: begin
        result_d = res_nx;
        neg_d = res_nx[22];
        done0_d = ~owner_q;
        done1_d = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q <= 1'b0;
      owner_q <= 1'b0;
      ax_q <= '0;
      ay_q <= '0;
      bx_q <= '0;
      by_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      p1_q <= '0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      result_q <= '0;
      neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      owner_q <= owner_d;
      ax_q <= ax_d;
      ay_q <= ay_d;
      bx_q <= bx_d;
      by_q <= by_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      p1_q <= p1_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      result_q <= result_d;
      neg_q <= neg_d;
    end
  end
  assign bus.gnt0 = gnt0_q;
  assign bus.gnt1 = gnt1_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.result = result_q;
  assign bus.neg = neg_q;
  assign bus.busy = (state_q != IDLE);
endmodule

// File: doc/cross_mul_sched.md
CROSS_MUL_SCHED -- requirements
Module: cross_mul_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have ports req0 and req1, input, 1 bit each: cross-product request from requester 0 (vertex sort) and requester 1 (inside test).
REQ-004 SHALL have ports ax0, ay0, bx0, by0, input, 11 bits each, two's complement: requester-0 operands.
REQ-005 SHALL have ports ax1, ay1, bx1, by1, input, 11 bits each, two's complement: requester-1 operands.
REQ-006 SHALL have ports gnt0 and gnt1, output, 1 bit each: one-cycle operand-accept pulse.
REQ-007 SHALL have ports done0 and done1, output, 1 bit each: one-cycle result-valid pulse.
REQ-008 SHALL have port result, output, 23 bits, two's complement: ax*by - ay*bx.
REQ-009 SHALL have port neg, output, 1 bit: result < 0.
REQ-010 SHALL have port busy, output, 1 bit: state not IDLE.

Function
REQ-011 SHALL use one shared serial shift-add magnitude multiplier, 11 iterations per product, one bit per cycle, LSB first.
REQ-012 SHALL implement states IDLE -> MUL1 -> MUL2 -> SUB -> IDLE.
REQ-013 In IDLE with any req high at a rising edge, SHALL:
- latch the winner's four operands
- register gnt for that requester, high for exactly the next cycle
- enter MUL1 with iteration count 0.
REQ-014 SHALL arbitrate round-robin: when req0 and req1 are both high, grant the requester not served last; the last-served pointer after reset selects requester 0 first.
REQ-015 SHALL ignore req in every state except IDLE; a requester keeps req high until its gnt, and req still high after done is a new request.
REQ-016 MUL1 SHALL compute |ax|*|by| in 11 cycles, with sign = sign(ax) XOR sign(by), forced positive when either operand is 0; it SHALL then enter MUL2.
REQ-017 MUL2 SHALL compute ay*bx by the same rules in 11 cycles, then enter SUB.
REQ-018 SUB SHALL:
- re-apply the signs to both products
- register result = P1 - P2 at 23-bit signed width, which cannot overflow for any 11-bit operands, -1024 included
- register neg = result[22]
- pulse done for the served requester for one cycle
- return to IDLE.
REQ-019 Latency SHALL be fixed: gnt rises after edge k, done rises after edge k+23, independent of operand values.
REQ-020 result and neg SHALL hold their value until the next SUB.
REQ-021 After SUB, a new grant SHALL take place at the first IDLE edge, so back-to-back throughput is one result per 24 cycles.
REQ-022 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL be high in any cycle.
REQ-023 The done requester identity SHALL equal the identity granted for that operation, even if req levels change mid-operation.
REQ-024 Operand inputs SHALL be sampled only on the accept edge; later changes SHALL NOT affect the result.

Reset
REQ-025 reset SHALL asynchronously force:
- state IDLE
- gnt0, gnt1, done0, done1, busy, neg = 0
- result = 0
- round-robin pointer to favour requester 0
- iteration count and partial products to 0.
REQ-026 Reset asserted mid-operation SHALL abort it with no done pulse; the first request after deassertion SHALL be served normally from IDLE.

Verification
REQ-027 A bench SHALL apply req0 with ax=3, ay=2, bx=1, by=5 -> gnt0 one cycle, done0 23 cycles later, result=13, neg=0.
REQ-028 A bench SHALL apply req1 with ax=-4, ay=6, bx=7, by=2 -> done1, result=-50, neg=1.
REQ-029 A bench SHALL apply req0 with ax=-1024, ay=1023, bx=-1024, by=-1024 -> result=2096128 (ax*by=1048576, ay*bx=-1047552), no overflow, neg=0.
REQ-030 A bench SHALL hold req0 and req1 high together from reset -> grants alternate 0,1,0,1 with one result per 24 cycles, and done0/done1 each match their own operands.
REQ-031 A bench SHALL assert reset 10 cycles after gnt1 -> no done1, all outputs 0; a subsequent req1 with ax=by=0, ay=bx=5 -> result=-25.
REQ-032 A bench SHALL change the operand inputs one cycle after gnt0 -> the result reflects the operands latched at grant only.
